// File: rtl/pipe_pkg.sv
// Encodings shared by the ID-stage hazard logic and the operand select muxes.
package pipe_pkg;

    typedef enum logic [1:0] {
        SEL_RF = 2'd0,
        SEL_EX = 2'd1,
        SEL_ME = 2'd2,
        SEL_MO = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lstate_e;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding source selection and load-use detection for one ID-stage operand.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic [REG_W-1:0] rw_ex,
    input  logic             wreg_ex,
    input  logic             m2reg_ex,
    input  logic [REG_W-1:0] rw_me,
    input  logic             wreg_me,
    input  logic             m2reg_me,
    output logic [1:0]       sel,
    output logic             load_use
);

    logic src_nz;

    always_comb begin
        sel      = SEL_RF;
        load_use = 1'b0;
        src_nz   = |src;
        // The youngest producer (EX) shadows an older write of the same register in ME.
        if (src_nz && wreg_ex && (rw_ex == src)) begin
            sel      = SEL_EX;
            load_use = use_src & m2reg_ex;
        end else if (src_nz && wreg_me && (rw_me == src)) begin
            sel = m2reg_me ? SEL_MO : SEL_ME;
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard controller: operand forwarding, load-use stall, and a one-entry
// scoreboard tracking a single outstanding fixed-latency MUL/DIV.
module id_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LONG_LAT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset_0,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic [REG_W-1:0] rw_id,
    input  logic             wreg_id,
    input  logic             long_id,
    input  logic             flush_id,
    input  logic [REG_W-1:0] rw_ex,
    input  logic [REG_W-1:0] rw_me,
    input  logic             wreg_ex,
    input  logic             wreg_me,
    input  logic             m2reg_ex,
    input  logic             m2reg_me,
    output logic [1:0]       a_select,
    output logic [1:0]       b_select,
    output logic             stall,
    output logic             long_busy,
    output logic             long_wb,
    output logic [REG_W-1:0] long_rw,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LONG_LAT - 2);

    lstate_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REG_W-1:0] long_rw_q, long_rw_d;
    logic             long_wb_q, long_wb_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic lu_a, lu_b;
    logic busy_st, long_nz, raw_a, raw_b, waw, structural, issue;

    fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .src(rs_id), .use_src(use_rs_id),
        .rw_ex(rw_ex), .wreg_ex(wreg_ex), .m2reg_ex(m2reg_ex),
        .rw_me(rw_me), .wreg_me(wreg_me), .m2reg_me(m2reg_me),
        .sel(a_select), .load_use(lu_a)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .src(rt_id), .use_src(use_rt_id),
        .rw_ex(rw_ex), .wreg_ex(wreg_ex), .m2reg_ex(m2reg_ex),
        .rw_me(rw_me), .wreg_me(wreg_me), .m2reg_me(m2reg_me),
        .sel(b_select), .load_use(lu_b)
    );

    // Only BUSY blocks on long_rw: in DONE the falling-edge regfile write is visible to ID.
    always_comb begin
        busy_st    = (state_q == BUSY);
        long_nz    = |long_rw_q;
        raw_a      = busy_st & long_nz & use_rs_id & (rs_id == long_rw_q);
        raw_b      = busy_st & long_nz & use_rt_id & (rt_id == long_rw_q);
        waw        = busy_st & long_nz & wreg_id & (rw_id == long_rw_q);
        structural = busy_st & long_id;
        stall      = ~flush_id & (lu_a | lu_b | raw_a | raw_b | waw | structural);
        issue      = long_id & wreg_id & ~stall & ~flush_id;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        long_rw_d = long_rw_q;
        case (state_q)
            IDLE: if (issue) state_d = BUSY;
            BUSY: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = DONE;
            end
            DONE:    state_d = issue ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
        if (issue) begin
            long_rw_d = rw_id;
            cnt_d     = LAT_LOAD;
        end
        long_wb_d     = (state_d == DONE);
        stall_count_d = (stall && (stall_count_q != CNT_MAX)) ? stall_count_q + 1'b1
                                                               : stall_count_q;
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            long_rw_q     <= '0;
            long_wb_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            long_rw_q     <= long_rw_d;
            long_wb_q     <= long_wb_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign long_busy   = (state_q != IDLE);
    assign long_wb     = long_wb_q;
    assign long_rw     = long_rw_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard (LONG_LAT=4, CNT_W=4) with hand-computed expectations.
module tb_id_hazard_scoreboard;

    localparam int REG_W    = 5;
    localparam int LONG_LAT = 4;
    localparam int CNT_W    = 4;

    logic             clk;
    logic             reset_0;
    logic [REG_W-1:0] rs_id, rt_id, rw_id, rw_ex, rw_me;
    logic             use_rs_id, use_rt_id, wreg_id, long_id, flush_id;
    logic             wreg_ex, wreg_me, m2reg_ex, m2reg_me;
    logic [1:0]       a_select, b_select;
    logic             stall, long_busy, long_wb;
    logic [REG_W-1:0] long_rw;
    logic [CNT_W-1:0] stall_count;

    int errors = 0;
    int checks = 0;

    id_hazard_scoreboard #(.REG_W(REG_W), .LONG_LAT(LONG_LAT), .CNT_W(CNT_W)) dut (
        .clock(clk), .reset_0(reset_0),
        .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .rw_id(rw_id), .wreg_id(wreg_id), .long_id(long_id), .flush_id(flush_id),
        .rw_ex(rw_ex), .rw_me(rw_me), .wreg_ex(wreg_ex), .wreg_me(wreg_me),
        .m2reg_ex(m2reg_ex), .m2reg_me(m2reg_me),
        .a_select(a_select), .b_select(b_select), .stall(stall),
        .long_busy(long_busy), .long_wb(long_wb), .long_rw(long_rw),
        .stall_count(stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        rs_id = '0; rt_id = '0; rw_id = '0; rw_ex = '0; rw_me = '0;
        use_rs_id = 0; use_rt_id = 0; wreg_id = 0; long_id = 0; flush_id = 0;
        wreg_ex = 0; wreg_me = 0; m2reg_ex = 0; m2reg_me = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_long(input logic [REG_W-1:0] rd);
        clear_in();
        long_id = 1; wreg_id = 1; rw_id = rd;
        #1;
        chk("issue_stall", stall, 0);
    endtask

    initial begin
        clear_in();
        reset_0 = 1'b0;
        #12;
        chk("rst_busy", long_busy, 0);
        chk("rst_wb", long_wb, 0);
        chk("rst_rw", long_rw, 0);
        chk("rst_cnt", stall_count, 0);
        reset_0 = 1'b1;
        step();

        // 1: forwarding priority
        rs_id = 5; use_rs_id = 1; rw_ex = 5; wreg_ex = 1; rw_me = 5; wreg_me = 1;
        #1;
        chk("fwd_ex_prio", a_select, 1);
        chk("fwd_ex_stall", stall, 0);
        chk("fwd_b_rf", b_select, 0);
        wreg_ex = 0; m2reg_me = 1;
        #1;
        chk("fwd_mo", a_select, 3);
        m2reg_me = 0;
        #1;
        chk("fwd_me", a_select, 2);
        clear_in(); rw_ex = 0; wreg_ex = 1; use_rs_id = 1;
        #1;
        chk("fwd_r0", a_select, 0);

        // 2: load-use on rt
        clear_in(); rt_id = 7; use_rt_id = 1; rw_ex = 7; wreg_ex = 1; m2reg_ex = 1;
        #1;
        chk("lu_stall", stall, 1);
        chk("lu_bsel", b_select, 1);
        step(); step(); step();
        chk("lu_cnt3", stall_count, 3);
        rt_id = 0; rw_ex = 0;
        #1;
        chk("lu_r0_stall", stall, 0);
        chk("lu_r0_bsel", b_select, 0);
        step();
        chk("lu_cnt_hold", stall_count, 3);

        // 3: single long op, rw=9, cycle 0 = issue cycle
        issue_long(9);
        step();
        clear_in(); rs_id = 9; use_rs_id = 1;
        #1;
        chk("c1_busy", long_busy, 1);
        chk("c1_raw", stall, 1);
        chk("c1_rw", long_rw, 9);
        chk("c1_wb", long_wb, 0);
        step();
        clear_in(); wreg_id = 1; rw_id = 9;
        #1;
        chk("c2_waw", stall, 1);
        step();
        clear_in(); rs_id = 9; use_rs_id = 1;
        #1;
        chk("c3_raw", stall, 1);
        chk("c3_wb", long_wb, 0);
        step();
        #1;
        chk("c4_wb", long_wb, 1);
        chk("c4_stall", stall, 0);
        chk("c4_rw", long_rw, 9);
        chk("c4_busy", long_busy, 1);
        step();
        clear_in();
        #1;
        chk("c5_busy", long_busy, 0);
        chk("c5_wb", long_wb, 0);
        chk("c5_cnt", stall_count, 6);

        // 4: back-to-back long ops
        issue_long(9);
        step();
        for (int c = 1; c <= 3; c++) begin
            long_id = 1; wreg_id = 1; rw_id = 10;
            #1;
            chk("b2b_struct", stall, 1);
            chk("b2b_rw9", long_rw, 9);
            step();
        end
        #1;
        chk("b2b_c4_wb", long_wb, 1);
        chk("b2b_c4_stall", stall, 0);
        step();
        clear_in(); wreg_id = 1; rw_id = 10;
        #1;
        chk("b2b_c5_busy", long_busy, 1);
        chk("b2b_c5_rw", long_rw, 10);
        chk("b2b_c5_waw", stall, 1);
        step();
        clear_in();
        step();
        #1;
        chk("b2b_c7_wb", long_wb, 0);
        step();
        #1;
        chk("b2b_c8_wb", long_wb, 1);
        chk("b2b_c8_rw", long_rw, 10);
        step();
        #1;
        chk("b2b_c9_busy", long_busy, 0);
        chk("b2b_cnt", stall_count, 10);

        // 5: asynchronous reset in the middle of BUSY
        issue_long(11);
        step();
        clear_in(); rs_id = 11; use_rs_id = 1;
        step();
        #1;
        chk("mid_stall_pre", stall, 1);
        #1;
        reset_0 = 1'b0;
        #1;
        chk("ar_busy", long_busy, 0);
        chk("ar_wb", long_wb, 0);
        chk("ar_cnt", stall_count, 0);
        chk("ar_rw", long_rw, 0);
        chk("ar_stall", stall, 0);
        @(posedge clk);
        #1;
        reset_0 = 1'b1;
        clear_in();
        step();

        // 6: saturation and flush
        rs_id = 3; use_rs_id = 1; rw_ex = 3; wreg_ex = 1; m2reg_ex = 1;
        for (int i = 0; i < 20; i++) step();
        chk("sat_15", stall_count, 15);
        step();
        chk("sat_hold", stall_count, 15);
        flush_id = 1; long_id = 1; wreg_id = 1; rw_id = 12;
        #1;
        chk("flush_stall", stall, 0);
        step();
        chk("flush_no_issue", long_busy, 0);
        chk("flush_cnt", stall_count, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
